i2s_tx_sequencer: RTL and testbench

Transmit-side I2S master sequencer for the I2S test design. It divides the system clock into BCLK, derives LRCLK from a 32-slot frame counter, and serialises one stereo sample pair per frame on SDATA. A one-deep ready/valid holding buffer decouples it from the sample source, e.g. the free-running test counter that feeds sample values. It replaces the ad-hoc negedge oscillator divider with a single-clock, synchronously reset scheduler.

---
 rtl/i2s_tx_sequencer.sv | 105 ++++++++++
 tb/tb_i2s_tx_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_sequencer.sv
// I2S transmit master: divides clk into BCLK, sequences a 32-slot LRCLK frame and
// serialises one buffered stereo sample pair per frame, MSB first.
module i2s_tx_sequencer #(
    parameter int DIV      = 32,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] left_data,
    input  logic [SAMPLE_W-1:0] right_data,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata,
    output logic                frame_start,
    output logic                underrun
);

    localparam int FRAME_W = 2 * SAMPLE_W;
    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    logic [7:0]         div_cnt;
    logic [4:0]         slot;
    logic [FRAME_W-1:0] hold_buf;
    logic [FRAME_W-1:0] shift_reg;

    logic       div_wrap;
    logic       fall_evt;
    logic       accept;
    logic [4:0] slot_nxt;
    logic       lr_nxt;

    always_comb begin
        div_wrap = (div_cnt == DIV_LAST);
        fall_evt = enable && div_wrap && bclk;
        accept   = sample_valid && sample_ready;
        slot_nxt = slot + 5'd1;
        // LRCLK switches one slot ahead of the channel MSB
        lr_nxt   = (slot_nxt >= 5'd15) && (slot_nxt <= 5'd30);
    end

    // Sample payload only; its occupancy is tracked by sample_ready.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_buf <= {left_data, right_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt      <= 8'd0;
            slot         <= 5'd31;
            bclk         <= 1'b0;
            lrclk        <= 1'b0;
            sdata        <= 1'b0;
            sample_ready <= 1'b1;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
            shift_reg    <= '0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            if (accept) begin
                sample_ready <= 1'b0;
            end
            if (!enable) begin
                div_cnt <= 8'd0;
                slot    <= 5'd31;
                bclk    <= 1'b0;
                lrclk   <= 1'b0;
                sdata   <= 1'b0;
            end else begin
                if (div_wrap) begin
                    div_cnt <= 8'd0;
                    bclk    <= ~bclk;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
                if (fall_evt) begin
                    slot  <= slot_nxt;
                    lrclk <= lr_nxt;
                    if (slot_nxt == 5'd0) begin
                        frame_start <= 1'b1;
                        // A same-cycle handshake is not bypassed; it waits for the next frame.
                        if (!sample_ready) begin
                            shift_reg    <= {hold_buf[FRAME_W-2:0], 1'b0};
                            sdata        <= hold_buf[FRAME_W-1];
                            sample_ready <= 1'b1;
                        end else begin
                            shift_reg <= '0;
                            sdata     <= 1'b0;
                            underrun  <= 1'b1;
                        end
                    end else begin
                        sdata     <= shift_reg[FRAME_W-1];
                        shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Scoreboard bench for i2s_tx_sequencer at DIV=4: accepted samples are queued and
// compared against each serialised frame captured on BCLK falling edges.
module tb_i2s_tx_sequencer;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] left_data = 16'h0;
    logic [15:0] right_data = 16'h0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        frame_start;
    logic        underrun;

    i2s_tx_sequencer #(.DIV(DIV), .SAMPLE_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .left_data(left_data),
        .right_data(right_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .bclk(bclk),
        .lrclk(lrclk),
        .sdata(sdata),
        .frame_start(frame_start),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard / monitor state
    logic [31:0] q[$];
    logic        pend = 1'b0;
    logic [31:0] pend_w = 32'h0;
    logic        en_q = 1'b0;
    logic        rst_q = 1'b1;
    logic        bclk_q = 1'b0;
    logic        cap = 1'b0;
    logic        cont = 1'b0;
    logic [31:0] exp_w = 32'h0;
    logic [31:0] dat_w = 32'h0;
    logic [31:0] lr_w = 32'h0;
    int          idx = 0;
    int          cyc = 0;
    int          last_fs = 0;
    int          n_frames = 0;
    int          idle_viol = 0;

    always @(negedge clk) begin
        logic fall;
        cyc++;
        fall = bclk_q && !bclk && en_q && !rst_q;
        if (rst_q) begin
            q.delete();
        end
        if (!en_q || rst_q) begin
            cap  = 1'b0;
            cont = 1'b0;
            if (bclk || lrclk || sdata || frame_start || underrun) idle_viol++;
        end else begin
            if (underrun && !frame_start) chk("underrun_without_fs", 32'(underrun), 32'd0);
            if (frame_start) begin
                chk("fs_on_bclk_fall", 32'(fall), 32'd1);
                if (cap) chk("fs_early", 32'(idx), 32'd32);
                if (cont) chk("fs_period", 32'(cyc - last_fs), 32'(64 * DIV));
                cont    = 1'b1;
                last_fs = cyc;
                if (q.size() == 0) begin
                    chk("underrun_flag", 32'(underrun), 32'd1);
                    exp_w = 32'h0;
                end else begin
                    chk("underrun_flag", 32'(underrun), 32'd0);
                    exp_w = q.pop_front();
                end
                cap   = 1'b1;
                idx   = 0;
                dat_w = 32'h0;
                lr_w  = 32'h0;
            end else if (fall && !cap) begin
                chk("slot_sequence", 32'(cap), 32'd1);
            end
            if (fall && cap) begin
                dat_w[31-idx] = sdata;
                lr_w[31-idx]  = lrclk;
                idx++;
                if (idx == 32) begin
                    chk("sdata_frame", dat_w, exp_w);
                    chk("lrclk_frame", lr_w, 32'h0001FFFE);
                    n_frames++;
                    cap = 1'b0;
                end
            end
        end
        if (pend) q.push_back(pend_w);
        pend   = sample_valid && sample_ready && !rst;
        pend_w = {left_data, right_data};
        en_q   = enable;
        rst_q  = rst;
        bclk_q = bclk;
    end

    task automatic wait_fs();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!frame_start && t < 4000);
        if (!frame_start) chk("fs_timeout", 32'(frame_start), 32'd1);
    endtask

    task automatic enable_timed();
        int n = 0;
        @(posedge clk); #1;
        enable = 1'b1;
        @(negedge clk);
        while (!frame_start && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk("first_fs_latency", 32'(n), 32'(2 * DIV));
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        int   t = 0;
        logic hs = 1'b0;
        @(posedge clk); #1;
        left_data    = l;
        right_data   = r;
        sample_valid = 1'b1;
        while (!hs && t < 4000) begin
            @(negedge clk);
            hs = sample_ready;
            t++;
            @(posedge clk); #1;
        end
        sample_valid = 1'b0;
        chk("send_handshake", 32'(hs), 32'd1);
    endtask

    initial begin
        // Reset with enable high
        rst = 1'b1;
        enable = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_outputs", 32'({bclk, lrclk, sdata, sample_ready, frame_start, underrun}), 32'b000100);

        // Idle while disabled
        @(posedge clk); #1;
        rst = 1'b0;
        enable = 1'b0;
        repeat (500) @(negedge clk);
        chk("idle_outputs", 32'(idle_viol), 32'd0);
        chk("idle_ready", 32'(sample_ready), 32'd1);

        // Preload and basic frame
        send(16'hA5C3, 16'h0F81);
        chk("ready_after_accept", 32'(sample_ready), 32'd0);
        enable_timed();

        // Empty buffer -> underrun frame; then a handshake in the load cycle
        wait_fs();
        chk("underrun_empty", 32'(underrun), 32'd1);
        repeat (254) @(negedge clk);
        @(posedge clk); #1;
        left_data = 16'h1234;
        right_data = 16'h5678;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        wait_fs();
        chk("underrun_load_cycle", 32'(underrun), 32'd1);
        chk("stored_for_next", 32'(sample_ready), 32'd0);

        // Back-pressure: valid held high with incrementing data
        begin
            int   k = 0;
            int   t = 0;
            int   last = 0;
            logic hs;
            @(posedge clk); #1;
            left_data = 16'h1000;
            right_data = 16'hE000;
            sample_valid = 1'b1;
            while (k < 5 && t < 3000) begin
                @(negedge clk);
                t++;
                hs = sample_valid && sample_ready;
                @(posedge clk); #1;
                if (hs) begin
                    if (k >= 2) chk("handshake_gap", 32'(t - last), 32'(64 * DIV));
                    last = t;
                    k++;
                    left_data = left_data + 16'd1;
                    right_data = right_data - 16'd3;
                end
            end
            sample_valid = 1'b0;
            chk("handshake_count", 32'(k), 32'd5);
        end

        // Mid-frame disable, re-enable with a buffered sample
        wait_fs();
        repeat (20 * DIV) @(negedge clk);
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("disable_outputs", 32'({bclk, lrclk, sdata}), 32'd0);
        send(16'h5A5A, 16'hC3C3);
        enable_timed();
        chk("reenable_loaded", 32'(underrun), 32'd0);

        // Mid-frame disable, re-enable with an empty buffer
        repeat (20 * DIV) @(negedge clk);
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("disable_outputs_2", 32'({bclk, lrclk, sdata}), 32'd0);
        enable_timed();
        chk("reenable_underrun", 32'(underrun), 32'd1);
        wait_fs();

        // Mid-frame reset with the buffer full
        send(16'hBEEF, 16'h1357);
        chk("buffer_full_before_rst", 32'(sample_ready), 32'd0);
        repeat (150) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mid_outputs", 32'({bclk, lrclk, sdata, sample_ready, frame_start, underrun}), 32'b000100);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_fs();
        chk("post_rst_underrun", 32'(underrun), 32'd1);
        wait_fs();

        chk("frames_completed", 32'(n_frames >= 10), 32'd1);
        chk("idle_outputs_final", 32'(idle_viol), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
